// File: rtl/memory_bus_master.sv
// memory_bus_master: single-outstanding initiator for the single-port memory bus.
// Runs an optional chip-enable CSR write after reset, then one command per transaction, one result each.
module memory_bus_master #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_SIZE    = 16,
    parameter bit AUTO_EN     = 1'b1,
    parameter int RSP_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_wr,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_response,
    output logic                  init_done,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count,
    output logic [15:0]           err_count
);
    typedef enum logic [2:0] {INIT, IDLE, WR, WR_WAIT, RD, RD_CAP, DONE} state_t;
    localparam logic [ADDR_WIDTH-1:0] MEM_LIM = ADDR_WIDTH'(MEM_SIZE);
    localparam logic [7:0]            TMR_MAX = 8'(RSP_TIMEOUT - 1);
    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic                  mem_wr_q, mem_wr_d, init_done_q, init_done_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d, mem_wdata_q, mem_wdata_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]           wr_count_q, wr_count_d, rd_count_q, rd_count_d, err_count_q, err_count_d;
    logic [7:0]            tmr_q, tmr_d;
    logic                  is_csr;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign is_csr = mem_addr_q >= MEM_LIM;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        init_done_d = init_done_q;
        wr_count_d  = wr_count_q;
        rd_count_d  = rd_count_q;
        err_count_d = err_count_q;
        tmr_d       = tmr_q;
        case (state_q)
            INIT: begin
                // First cycle issues the enable strobe, second cycle retires it.
                if (!mem_wr_q) begin
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = ADDR_WIDTH'(32'h20);
                    mem_wdata_d = DATA_WIDTH'(1);
                end else begin
                    state_d     = IDLE;
                    cmd_ready_d = 1'b1;
                    init_done_d = 1'b1;
                end
            end
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d    = cmd_wr ? WR : RD;
                    mem_wr_d   = cmd_wr;
                    mem_addr_d = cmd_addr;
                    if (cmd_wr) mem_wdata_d = cmd_wdata;
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            WR: begin
                state_d = WR_WAIT;
                tmr_d   = 8'd0;
            end
            WR_WAIT: begin
                if (is_csr || mem_response || tmr_q == TMR_MAX) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = !is_csr && !mem_response;
                    if (!is_csr) begin
                        wr_count_d  = mem_response ? sat_inc(wr_count_q) : wr_count_q;
                        err_count_d = mem_response ? err_count_q : sat_inc(err_count_q);
                    end
                end else begin
                    tmr_d = tmr_q + 8'd1;
                end
            end
            RD: state_d = RD_CAP;
            RD_CAP: begin
                state_d     = DONE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = mem_rdata;
                rsp_err_d   = 1'b0;
                rd_count_d  = sat_inc(rd_count_q);
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= AUTO_EN ? INIT : IDLE;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            init_done_q <= !AUTO_EN;
            wr_count_q  <= '0;
            rd_count_q  <= '0;
            err_count_q <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            init_done_q <= init_done_d;
            wr_count_q  <= wr_count_d;
            rd_count_q  <= rd_count_d;
            err_count_q <= err_count_d;
            tmr_q       <= tmr_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign init_done = init_done_q;
    assign wr_count  = wr_count_q;
    assign rd_count  = rd_count_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_memory_bus_master.sv
// tb_memory_bus_master: directed plus randomized commands against a behavioural memory slave,
// with expected data, latency, error flag and counters predicted from a simple array model.
module tb_memory_bus_master;
    localparam int TO = 4;
    logic        clk = 1'b0;
    logic        reset, cmd_valid, cmd_ready, cmd_wr, rsp_valid, rsp_ready, rsp_err;
    logic [15:0] cmd_addr, mem_addr, wr_count, rd_count, err_count;
    logic [31:0] cmd_wdata, rsp_rdata, mem_wdata, mem_rdata;
    logic        mem_wr, mem_response, init_done;
    int checks = 0, errors = 0;

    logic [31:0] smem [16];
    logic [31:0] s_scr = '0, s_en = '0, s_wcnt = '0;
    int          rdly = 0, rcnt = 0;
    bit          resp_en = 1'b1;

    logic [31:0] mdl [16];
    logic [31:0] m_scr = '0;
    int          m_wc = 0, m_rc = 0, m_ec = 0;

    memory_bus_master #(.RSP_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_response(mem_response),
        .init_done(init_done), .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Slave: registered read data, write response after rdly extra cycles.
    always @(posedge clk) begin
        mem_response <= 1'b0;
        if (rcnt > 0) begin
            rcnt <= rcnt - 1;
            if (rcnt == 1) mem_response <= 1'b1;
        end
        if (mem_wr) begin
            if (mem_addr < 16) smem[mem_addr[3:0]] <= mem_wdata;
            else if (mem_addr == 16'h24) s_scr <= mem_wdata;
            else if (mem_addr == 16'h20) s_en <= mem_wdata;
            s_wcnt <= s_wcnt + 1;
            if (resp_en && mem_addr < 16) begin
                if (rdly == 0) mem_response <= 1'b1;
                else rcnt <= rdly;
            end
        end
        mem_rdata <= (mem_addr < 16) ? smem[mem_addr[3:0]] : (mem_addr == 16'h24) ? s_scr :
                     (mem_addr == 16'h20) ? s_en : (mem_addr == 16'h18) ? s_wcnt : 32'h0;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters();
        chk("wr_count", 64'(wr_count), 64'(m_wc));
        chk("rd_count", 64'(rd_count), 64'(m_rc));
        chk("err_count", 64'(err_count), 64'(m_ec));
    endtask

    task automatic chk_startup();
        @(negedge clk);
        chk("init_strobe", 64'(mem_wr), 64'd1);
        chk("init_addr", 64'(mem_addr), 64'h20);
        chk("init_wdata", 64'(mem_wdata), 64'd1);
        chk("init_busy", 64'({cmd_ready, init_done}), 64'd0);
        @(negedge clk);
        chk("init_end", 64'({mem_wr, cmd_ready, init_done}), 64'b011);
        chk_counters();
    endtask

    // dly < 0: slave never responds; otherwise response visible dly cycles after the fastest slot.
    task automatic do_cmd(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                          input int dly, input int hold);
        bit          is_mem = addr < 16;
        bit          exp_err = wr && is_mem && (dly < 0 || dly >= TO);
        int          exp_lat = (wr && is_mem) ? (exp_err ? 1 + TO : 2 + dly) : 2;
        logic [31:0] exp_rd = wr ? 32'h0 : is_mem ? mdl[addr[3:0]] : (addr == 16'h24) ? m_scr : 32'h0;
        logic [15:0] a0;
        int          lat, i;
        for (i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        resp_en = dly >= 0;
        rdly = (dly < 0) ? 0 : dly;
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
        chk("bus_addr", 64'(mem_addr), 64'(addr));
        chk("bus_wr", 64'(mem_wr), 64'(wr));
        if (wr) chk("bus_wdata", 64'(mem_wdata), 64'(wd));
        for (lat = 1; lat <= 30; lat++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        if (wr) begin
            if (is_mem) mdl[addr[3:0]] = wd;
            else if (addr == 16'h24) m_scr = wd;
            if (is_mem && exp_err) m_ec++;
            else if (is_mem) m_wc++;
        end else m_rc++;
        chk_counters();
        a0 = mem_addr;
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 64'({rsp_valid, cmd_ready, mem_wr}), 64'b100);
            chk("hold_data", 64'(rsp_rdata), 64'(exp_rd));
            chk("hold_addr", 64'(mem_addr), 64'(a0));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("after_accept", 64'({rsp_valid, cmd_ready}), 64'b01);
    endtask

    initial begin
        int sel;
        for (int i = 0; i < 16; i++) begin smem[i] = '0; mdl[i] = '0; end
        reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        mem_response = 1'b0; mem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_bus", 64'({mem_wr, mem_addr, mem_wdata}), 64'd0);
        chk("rst_ctl", 64'({cmd_ready, rsp_valid, rsp_err, init_done}), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        chk_counters();
        reset = 1'b0;
        chk_startup();

        do_cmd(1'b1, 16'd3, 32'hDEADBEEF, 0, 0);
        do_cmd(1'b0, 16'd3, 32'h0, 0, 0);
        do_cmd(1'b1, 16'd5, 32'h12345678, -1, 0);
        do_cmd(1'b1, 16'h24, 32'h55, -1, 0);
        do_cmd(1'b0, 16'h24, 32'h0, 0, 0);
        do_cmd(1'b1, 16'd7, 32'hA5A5A5A5, 3, 0);
        do_cmd(1'b1, 16'd8, 32'h5A5A5A5A, 4, 0);
        do_cmd(1'b0, 16'd3, 32'h0, 0, 10);

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 16));
            do_cmd(1'($urandom_range(0, 1)), (sel == 16) ? 16'h24 : 16'(sel), $urandom,
                   int'($urandom_range(0, 5)) - 1, int'($urandom_range(0, 2)));
        end

        for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'd3;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        m_wc = 0; m_rc = 0; m_ec = 0;
        chk("midrst_ctl", 64'({rsp_valid, cmd_ready, mem_wr, init_done}), 64'd0);
        chk_counters();
        @(posedge clk);
        @(negedge clk);
        chk("midrst_hold", 64'(rsp_valid), 64'd0);
        reset = 1'b0;
        chk_startup();
        do_cmd(1'b0, 16'd3, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
